// File: rtl/axis_pack_write_controller.sv
// Packs non-zero sorter FIFO items into wide AXI-Stream beats.
// Partial beats are closed on flush; tlast delimits fixed-size packets.
module axis_pack_write_controller #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_SORTER_BIT_WIDTH = 256,
  parameter int C_BEATS_PER_BURST  = 16,
  parameter int C_CNT_WIDTH        = 32
) (
  input  logic                            m_axis_aclk,
  input  logic                            m_axis_areset,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast,
  input  logic                            read_fifo_out,
  input  logic [C_SORTER_BIT_WIDTH-1:0]   out_fifo_item,
  output logic                            fifo_out_i_deq,
  input  logic                            flush,
  output logic [C_CNT_WIDTH-1:0]          beat_count,
  output logic                            idle
);

  localparam int TW = C_AXIS_TDATA_WIDTH;
  localparam int SW = C_SORTER_BIT_WIDTH;
  localparam int K  = TW / SW;
  localparam int KB = TW / 8;
  localparam int SB = SW / 8;
  localparam int LW = (K > 1) ? $clog2(K) : 1;
  localparam int NB = (K > 1) ? K - 1 : 1;
  localparam int BW = (C_BEATS_PER_BURST > 1) ?
                      $clog2(C_BEATS_PER_BURST) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(K - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(C_BEATS_PER_BURST - 1);

  logic [LW-1:0]      lane_q, lane_d;
  logic [NB*SW-1:0]   buf_q, buf_d;
  logic [BW-1:0]      burst_q, burst_d;
  logic               fpend_q, fpend_d;
  logic               tvalid_q, tlast_q;
  logic [TW-1:0]      tdata_q;
  logic [KB-1:0]      tkeep_q;
  logic [C_CNT_WIDTH-1:0] cnt_q;

  logic          out_free, item_nz, lane_last;
  logic          deq, take, fl;
  logic          load, ld_last, set_last;
  logic [TW-1:0] ld_data;
  logic [KB-1:0] ld_keep;

  always_comb begin
    out_free  = !tvalid_q || m_axis_tready;
    item_nz   = |out_fifo_item;
    lane_last = (lane_q == LAST_LANE);
    deq       = read_fifo_out && !fpend_q &&
                (!item_nz || !lane_last || out_free);
    take      = deq && item_nz;
    fl        = flush || fpend_q;
    lane_d    = lane_q;
    buf_d     = buf_q;
    burst_d   = burst_q;
    fpend_d   = 1'b0;
    load      = 1'b0;
    ld_data   = '0;
    ld_keep   = '0;
    ld_last   = 1'b0;
    set_last  = 1'b0;
    if (take && !lane_last) begin
      for (int i = 0; i < K - 1; i++)
        if (lane_q == LW'(i))
          buf_d[i*SW +: SW] = out_fifo_item;
      lane_d = lane_q + LW'(1);
    end
    if (take && lane_last) begin
      load = 1'b1;
      for (int i = 0; i < K - 1; i++)
        ld_data[i*SW +: SW] = buf_q[i*SW +: SW];
      ld_data[TW-1 -: SW] = out_fifo_item;
      ld_keep = '1;
      ld_last = fl || (burst_q == LAST_BEAT);
      lane_d  = '0;
    end else if (fl && lane_d != '0) begin
      if (out_free) begin
        load = 1'b1;
        for (int i = 0; i < K - 1; i++)
          if (LW'(i) < lane_d) begin
            ld_data[i*SW +: SW] = buf_d[i*SW +: SW];
            ld_keep[i*SB +: SB] = '1;
          end
        ld_last = 1'b1;
        lane_d  = '0;
      end else begin
        fpend_d = 1'b1;
      end
    end else if (fl) begin
      // nothing buffered: close the packet on the held beat, if any
      set_last = tvalid_q && !m_axis_tready;
      burst_d  = '0;
    end
    if (load)
      burst_d = ld_last ? '0 : burst_q + BW'(1);
  end

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      lane_q   <= '0;
      buf_q    <= '0;
      burst_q  <= '0;
      fpend_q  <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      lane_q  <= lane_d;
      buf_q   <= buf_d;
      burst_q <= burst_d;
      fpend_q <= fpend_d;
      if (load) begin
        tvalid_q <= 1'b1;
        tdata_q  <= ld_data;
        tkeep_q  <= ld_keep;
        tlast_q  <= ld_last;
      end else if (tvalid_q && m_axis_tready) begin
        tvalid_q <= 1'b0;
      end else if (set_last) begin
        tlast_q <= 1'b1;
      end
      if (tvalid_q && m_axis_tready)
        cnt_q <= cnt_q + C_CNT_WIDTH'(1);
    end
  end

  assign fifo_out_i_deq = deq;
  assign m_axis_tvalid  = tvalid_q;
  assign m_axis_tdata   = tdata_q;
  assign m_axis_tkeep   = tkeep_q;
  assign m_axis_tlast   = tlast_q;
  assign beat_count     = cnt_q;
  assign idle           = (lane_q == '0) && !tvalid_q && !fpend_q;

endmodule

// File: tb/tb_axis_pack_write_controller.sv
// Scoreboard bench: a list-based packing model predicts beats,
// a monitor pops and compares every accepted output beat.
module tb_axis_pack_write_controller;

  localparam int TW  = 512;
  localparam int SW  = 256;
  localparam int K   = TW / SW;
  localparam int KB  = TW / 8;
  localparam int SB  = SW / 8;
  localparam int BPB = 4;

  logic          clk = 1'b0;
  logic          areset, tvalid, tready, tlast;
  logic          rfo, deq, flush, idle;
  logic [TW-1:0] tdata;
  logic [KB-1:0] tkeep;
  logic [SW-1:0] item;
  logic [31:0]   bcnt;

  always #5 clk = ~clk;

  axis_pack_write_controller #(
    .C_AXIS_TDATA_WIDTH(TW),
    .C_SORTER_BIT_WIDTH(SW),
    .C_BEATS_PER_BURST(BPB),
    .C_CNT_WIDTH(32)
  ) dut (
    .m_axis_aclk(clk),
    .m_axis_areset(areset),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tdata(tdata),
    .m_axis_tkeep(tkeep),
    .m_axis_tlast(tlast),
    .read_fifo_out(rfo),
    .out_fifo_item(item),
    .fifo_out_i_deq(deq),
    .flush(flush),
    .beat_count(bcnt),
    .idle(idle)
  );

  typedef struct packed {
    logic [TW-1:0] d;
    logic [KB-1:0] k;
    logic          l;
  } beat_t;

  beat_t         exp_q[$];
  logic [SW-1:0] cur[$];
  logic [SW-1:0] fifo[$];
  int n_chk = 0, n_fail = 0;
  int pb = 0, loaded = 0, acc_m = 0, n_acc = 0, pend = 0;
  logic acc;
  logic hold_v = 1'b0;
  logic [TW-1:0] hold_d;
  logic [KB-1:0] hold_k;

  task automatic chk(string nm, logic [TW-1:0] act, logic [TW-1:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // one beat from the collected items; missing lanes stay zero
  task automatic emit(bit force_last);
    beat_t b;
    b = '0;
    foreach (cur[i]) begin
      b.d[i*SW +: SW] = cur[i];
      b.k[i*SB +: SB] = '1;
    end
    b.l = force_last || (pb == BPB - 1);
    pb  = b.l ? 0 : pb + 1;
    exp_q.push_back(b);
    loaded++;
    cur.delete();
  endtask

  always @(negedge clk) begin
    if (areset) begin
      exp_q.delete();
      cur.delete();
      pb = 0;
      loaded = 0;
      acc_m = 0;
    end else begin
      acc = tvalid && tready;
      if (deq && rfo && item != '0)
        cur.push_back(item);
      if (cur.size() == K) begin
        emit(flush);
      end else if (flush) begin
        if (cur.size() > 0) begin
          emit(1'b1);
        end else begin
          pend = loaded - acc_m - int'(acc);
          if (pend > 0) begin
            beat_t t;
            t = exp_q[exp_q.size()-1];
            t.l = 1'b1;
            exp_q[exp_q.size()-1] = t;
          end
          pb = 0;
        end
      end
      if (acc) acc_m++;
    end
  end

  always @(negedge clk) begin
    if (areset) begin
      hold_v = 1'b0;
      n_acc = 0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", TW'(tvalid), TW'(1));
        chk("hold_data", tdata, hold_d);
        chk("hold_keep", TW'(tkeep), TW'(hold_k));
      end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: got %h expected none", tdata);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_data", tdata, e.d);
          chk("beat_keep", TW'(tkeep), TW'(e.k));
          chk("beat_last", TW'(tlast), TW'(e.l));
        end
        n_acc++;
      end
      hold_v = tvalid && !tready;
      hold_d = tdata;
      hold_k = tkeep;
    end
  end

  function automatic logic [SW-1:0] rnd_item(int pz);
    logic [SW-1:0] v;
    if ($urandom_range(99) < pz) return '0;
    for (int w = 0; w < SW / 32; w++)
      v[w*32 +: 32] = $urandom;
    v[0] = 1'b1;
    return v;
  endfunction

  task automatic cyc(int pr_ready, int pr_flush, int pr_hold);
    logic took;
    @(negedge clk);
    took = deq && rfo;
    @(posedge clk);
    #1;
    if (took && fifo.size() > 0) void'(fifo.pop_front());
    rfo    = (fifo.size() > 0) && (int'($urandom_range(99)) >= pr_hold);
    item   = (fifo.size() > 0) ? fifo[0] : '0;
    tready = int'($urandom_range(99)) < pr_ready;
    flush  = int'($urandom_range(99)) < pr_flush;
  endtask

  task automatic chk_reset_state();
    chk("rst_tvalid", TW'(tvalid), TW'(0));
    chk("rst_tdata", tdata, TW'(0));
    chk("rst_tkeep", TW'(tkeep), TW'(0));
    chk("rst_tlast", TW'(tlast), TW'(0));
    chk("rst_beat_count", TW'(bcnt), TW'(0));
    chk("rst_idle", TW'(idle), TW'(1));
  endtask

  initial begin
    int pr [4][4];
    int guard;
    pr = '{'{100, 0, 30, 0}, '{50, 2, 10, 20},
           '{20, 5, 50, 40}, '{80, 10, 20, 10}};
    areset = 1'b1;
    tready = 1'b0;
    rfo    = 1'b0;
    item   = '0;
    flush  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state();
    @(posedge clk);
    #1 areset = 1'b0;

    for (int v = 1; v <= 4; v++) fifo.push_back(SW'(v));
    repeat (10) cyc(100, 0, 0);

    fifo.push_back(SW'(5));
    fifo.push_back(SW'(0));
    fifo.push_back(SW'(0));
    fifo.push_back(SW'(6));
    repeat (8) cyc(100, 0, 0);

    for (int v = 1; v <= 6; v++) fifo.push_back(SW'(v));
    repeat (10) cyc(0, 0, 0);
    repeat (12) cyc(100, 0, 0);

    for (int v = 1; v <= 16; v++) fifo.push_back(SW'(v + 100));
    repeat (24) cyc(100, 0, 0);

    fifo.push_back(SW'(7));
    repeat (3) cyc(100, 0, 0);
    cyc(100, 100, 0);
    repeat (4) cyc(100, 0, 0);
    @(negedge clk);
    chk("flush_idle", TW'(idle), TW'(1));
    @(posedge clk);
    #1;

    for (int p = 0; p < 4; p++)
      for (int c = 0; c < 1500; c++) begin
        if (fifo.size() < 3) fifo.push_back(rnd_item(pr[p][3]));
        cyc(pr[p][0], pr[p][1], pr[p][2]);
      end

    for (int v = 1; v <= 3; v++) fifo.push_back(SW'(v + 40));
    repeat (6) cyc(0, 0, 0);
    areset = 1'b1;
    rfo    = 1'b0;
    flush  = 1'b0;
    fifo.delete();
    @(posedge clk);
    #1 areset = 1'b0;
    @(negedge clk);
    chk_reset_state();
    @(posedge clk);
    #1;
    fifo.push_back(SW'(9));
    fifo.push_back(SW'(10));
    repeat (8) cyc(100, 0, 0);
    @(negedge clk);
    chk("post_reset_count", TW'(bcnt), TW'(1));
    @(posedge clk);
    #1;

    guard = 0;
    while (fifo.size() > 0 && guard < 300) begin
      cyc(100, 0, 0);
      guard++;
    end
    cyc(100, 100, 0);
    guard = 0;
    do begin
      cyc(100, 0, 0);
      guard++;
    end while ((exp_q.size() != 0 || !idle) && guard < 300);
    if (guard >= 300) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    repeat (2) cyc(100, 0, 0);
    @(negedge clk);
    chk("final_beat_count", TW'(bcnt), TW'(n_acc));
    chk("final_idle", TW'(idle), TW'(1));
    chk("final_pending", TW'(exp_q.size()), TW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
